// File: rtl/cellram_responder_pkg.sv
// Shared types and constants for the cell RAM responder.
package cellram_responder_pkg;

    localparam int LAT_CNT_W = 4;
    localparam logic [15:0] BAD_READ_WORD = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BURST,
        LATENCY,
        READ_BURST
    } state_e;

endpackage

// File: rtl/cellram_responder_if.sv
// Cell RAM control/address bus; mem_data is a separate inout on the responder.
interface cellram_responder_if #(
    parameter int ADDR_WIDTH = 23
);
    import cellram_responder_pkg::*;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_oe;
    logic                  mem_we;
    logic                  mem_addr_valid;
    logic                  mem_wait;

    modport master (
        output mem_addr, mem_oe, mem_we, mem_addr_valid,
        input  mem_wait
    );

    modport slave (
        input  mem_addr, mem_oe, mem_we, mem_addr_valid,
        output mem_wait
    );

endinterface

// File: rtl/cellram_store.sv
// Single-port synchronous RAM, registered read, write-first.
module cellram_store
    import cellram_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata_q   <= wdata;
        end else begin
            rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cellram_responder.sv
// Burst memory responder on the cell RAM bus with configurable read latency.
// Define CELLRAM_RESPONDER_BOUNDS_EN to flag and suppress out-of-range accesses.
module cellram_responder
    import cellram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = 23,
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cellram_responder_if.slave    bus,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  burst_active,
    output logic [31:0]           write_count,
    output logic [31:0]           read_count,
    output logic                  addr_error
);

`ifdef CELLRAM_RESPONDER_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [31:0]            wcnt_q, wcnt_d;
    logic [31:0]            rcnt_q, rcnt_d;
    logic                   err_q, err_d;
    logic                   rd_bad_q, rd_bad_d;

    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic                   wr_req, wr_bad, rd_adv, rd_bad;
    logic                   st_we;
    logic [DEPTH_LOG2-1:0]  st_addr;
    logic [DATA_WIDTH-1:0]  st_rdata, rd_word;
    logic                   drive_en;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> DEPTH_LOG2) != '0;
    endfunction

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        ptr_d     = ptr_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        err_d     = err_q;
        wr_req    = 1'b0;
        wr_addr   = ptr_q;
        rd_adv    = 1'b0;

        // A strobe restarts from any state, so it is decoded ahead of the state case.
        if (bus.mem_addr_valid) begin
            if (bus.mem_we) begin
                wr_req  = 1'b1;
                wr_addr = bus.mem_addr;
                ptr_d   = bus.mem_addr + ADDR_WIDTH'(1);
                state_d = WRITE_BURST;
            end else begin
                ptr_d = bus.mem_addr;
                if (READ_LATENCY <= 1) begin
                    state_d = READ_BURST;
                end else begin
                    state_d   = LATENCY;
                    lat_cnt_d = LAT_CNT_W'(READ_LATENCY - 1);
                end
            end
        end else begin
            case (state_q)
                WRITE_BURST: begin
                    if (bus.mem_we) begin
                        wr_req = 1'b1;
                        ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                LATENCY: begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                    if (lat_cnt_q <= LAT_CNT_W'(1)) state_d = READ_BURST;
                end
                READ_BURST: begin
                    if (bus.mem_we) begin
                        state_d = IDLE;
                    end else if (bus.mem_oe) begin
                        rd_adv = 1'b1;
                        ptr_d  = ptr_q + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end

        wr_bad   = BOUNDS_EN && out_of_range(wr_addr);
        rd_bad   = BOUNDS_EN && out_of_range(ptr_q);
        rd_bad_d = BOUNDS_EN && out_of_range(ptr_d);
        st_we    = wr_req && !wr_bad;
        if (st_we)  wcnt_d = wcnt_q + 32'd1;
        if (rd_adv) rcnt_d = rcnt_q + 32'd1;
        err_d = err_q | (wr_req & wr_bad) | (rd_adv & rd_bad);
        // Reads always target ptr_d so the registered word lines up with ptr_q next cycle.
        st_addr = st_we ? wr_addr[DEPTH_LOG2-1:0] : ptr_d[DEPTH_LOG2-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q    <= ptr_d;
        rd_bad_q <= rd_bad_d;
    end

    cellram_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk   (clk),
        .we    (st_we),
        .addr  (st_addr),
        .wdata (mem_data),
        .rdata (st_rdata)
    );

    assign rd_word  = rd_bad_q ? DATA_WIDTH'(BAD_READ_WORD) : st_rdata;
    // Enable depends only on registered state and the bus controls; we=1 always wins.
    assign drive_en = (state_q == READ_BURST) && bus.mem_oe && !bus.mem_we;
    assign mem_data = drive_en ? rd_word : {DATA_WIDTH{1'bz}};

    assign bus.mem_wait  = (state_q == LATENCY);
    assign burst_active  = (state_q != IDLE);
    assign write_count   = wcnt_q;
    assign read_count    = rcnt_q;
    assign addr_error    = err_q;

endmodule

// File: tb/tb_cellram_responder.sv
// Directed bench for cellram_responder (READ_LATENCY=2, DEPTH_LOG2=12).
module tb_cellram_responder;
    import cellram_responder_pkg::*;

    localparam int AW = 23;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    wire  [DW-1:0] mem_data;
    logic [DW-1:0] tb_wdata = '0;
    logic          tb_drive = 1'b0;
    logic          burst_active, addr_error;
    logic [31:0]   write_count, read_count;
    int            n_vec = 0;
    int            n_err = 0;

    cellram_responder_if #(.ADDR_WIDTH(AW)) bus();

    assign mem_data = tb_drive ? tb_wdata : {DW{1'bz}};

    cellram_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(12), .READ_LATENCY(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .mem_data     (mem_data),
        .burst_active (burst_active),
        .write_count  (write_count),
        .read_count   (read_count),
        .addr_error   (addr_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_addr_valid = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_oe = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [DW-1:0] d0, input int n);
        bus.mem_addr = a; bus.mem_addr_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_oe = 1'b0;
        tb_drive = 1'b1; tb_wdata = d0;
        tick();
        bus.mem_addr_valid = 1'b0;
        for (int i = 1; i < n; i++) begin
            tb_wdata = d0 + DW'(i);
            tick();
        end
        bus_idle();
        tick();
    endtask

    // Leaves the first word of the burst on mem_data.
    task automatic start_read(input logic [AW-1:0] a);
        bus.mem_addr = a; bus.mem_addr_valid = 1'b1; bus.mem_we = 1'b0; bus.mem_oe = 1'b1;
        tb_drive = 1'b0;
        tick();
        bus.mem_addr_valid = 1'b0;
        tick();
    endtask

    task automatic end_burst();
        bus.mem_oe = 1'b0; bus.mem_we = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        n_vec++; if (burst_active !== 1'b0) begin n_err++; $display("FAIL rst_burst_active: got %b expected 0", burst_active); end
        n_vec++; if (bus.mem_wait !== 1'b0) begin n_err++; $display("FAIL rst_mem_wait: got %b expected 0", bus.mem_wait); end
        n_vec++; if (write_count !== 32'd0 || read_count !== 32'd0) begin n_err++; $display("FAIL rst_counts: got w=%0d r=%0d expected 0/0", write_count, read_count); end
        n_vec++; if (addr_error !== 1'b0) begin n_err++; $display("FAIL rst_addr_error: got %b expected 0", addr_error); end
        n_vec++; if (dut.drive_en !== 1'b0) begin n_err++; $display("FAIL rst_drive: got %b expected 0", dut.drive_en); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_burst();
        bus.mem_addr = 23'h10; bus.mem_addr_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_oe = 1'b0;
        tb_drive = 1'b1; tb_wdata = 16'hA0;
        tick();
        n_vec++; if (burst_active !== 1'b1 || write_count !== 32'd1) begin n_err++; $display("FAIL wr_strobe: got active=%b wc=%0d expected 1/1", burst_active, write_count); end
        bus.mem_addr_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tb_wdata = 16'hA0 + DW'(i);
            tick();
        end
        bus_idle();
        tick();
        n_vec++; if (write_count !== 32'd4) begin n_err++; $display("FAIL wr_count: got %0d expected 4", write_count); end
        n_vec++; if (burst_active !== 1'b0) begin n_err++; $display("FAIL wr_end_idle: got %b expected 0", burst_active); end
    endtask

    task automatic test_read_burst();
        bus.mem_addr = 23'h10; bus.mem_addr_valid = 1'b1; bus.mem_we = 1'b0; bus.mem_oe = 1'b1;
        tick();
        bus.mem_addr_valid = 1'b0;
        n_vec++; if (bus.mem_wait !== 1'b1 || burst_active !== 1'b1 || dut.drive_en !== 1'b0) begin n_err++; $display("FAIL rd_latency: got wait=%b active=%b drv=%b expected 1/1/0", bus.mem_wait, burst_active, dut.drive_en); end
        tick();
        n_vec++; if (bus.mem_wait !== 1'b0) begin n_err++; $display("FAIL rd_wait_drop: got %b expected 0", bus.mem_wait); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (mem_data !== 16'hA0 + DW'(i) || read_count !== 32'(i)) begin n_err++; $display("FAIL rd_word%0d: got data=%h rc=%0d expected %h/%0d", i, mem_data, read_count, 16'hA0 + DW'(i), i); end
            tick();
        end
        n_vec++; if (read_count !== 32'd4) begin n_err++; $display("FAIL rd_count: got %0d expected 4", read_count); end
        end_burst();
        n_vec++; if (burst_active !== 1'b0 || write_count !== 32'd4) begin n_err++; $display("FAIL rd_abort: got active=%b wc=%0d expected 0/4", burst_active, write_count); end
    endtask

    task automatic test_pause();
        start_read(23'h10);
        tick();
        n_vec++; if (mem_data !== 16'hA1 || read_count !== 32'd5) begin n_err++; $display("FAIL pause_pre: got data=%h rc=%0d expected a1/5", mem_data, read_count); end
        bus.mem_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (read_count !== 32'd5 || burst_active !== 1'b1 || dut.drive_en !== 1'b0) begin n_err++; $display("FAIL pause_hold%0d: got rc=%0d active=%b drv=%b expected 5/1/0", i, read_count, burst_active, dut.drive_en); end
        end
        bus.mem_oe = 1'b1;
        #1;
        n_vec++; if (mem_data !== 16'hA1) begin n_err++; $display("FAIL pause_resume: got %h expected a1", mem_data); end
        tick();
        n_vec++; if (mem_data !== 16'hA2 || read_count !== 32'd6) begin n_err++; $display("FAIL pause_next: got data=%h rc=%0d expected a2/6", mem_data, read_count); end
        end_burst();
    endtask

    task automatic test_contention();
        start_read(23'h10);
        tb_drive = 1'b1; tb_wdata = 16'h7777;
        bus.mem_we = 1'b1; bus.mem_oe = 1'b1;
        #1;
        n_vec++; if (dut.drive_en !== 1'b0) begin n_err++; $display("FAIL cont_drive: got %b expected 0", dut.drive_en); end
        tick();
        n_vec++; if (burst_active !== 1'b0 || dut.drive_en !== 1'b0 || write_count !== 32'd4 || read_count !== 32'd6) begin n_err++; $display("FAIL cont_idle: got active=%b drv=%b wc=%0d rc=%0d expected 0/0/4/6", burst_active, dut.drive_en, write_count, read_count); end
        bus_idle();
        start_read(23'h10);
        n_vec++; if (mem_data !== 16'hA0) begin n_err++; $display("FAIL cont_store_kept: got %h expected a0", mem_data); end
        end_burst();
    endtask

    task automatic test_restart();
        bus.mem_addr = 23'h20; bus.mem_addr_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_oe = 1'b0;
        tb_drive = 1'b1; tb_wdata = 16'hC0;
        tick();
        bus.mem_addr_valid = 1'b0; tb_wdata = 16'hC1;
        tick();
        bus.mem_addr = 23'h30; bus.mem_addr_valid = 1'b1; tb_wdata = 16'hD0;
        tick();
        n_vec++; if (burst_active !== 1'b1 || write_count !== 32'd7) begin n_err++; $display("FAIL rs_strobe: got active=%b wc=%0d expected 1/7", burst_active, write_count); end
        bus.mem_addr_valid = 1'b0; tb_wdata = 16'hD1;
        tick();
        bus_idle();
        tick();
        n_vec++; if (write_count !== 32'd8) begin n_err++; $display("FAIL rs_count: got %0d expected 8", write_count); end
        start_read(23'h30);
        n_vec++; if (mem_data !== 16'hD0) begin n_err++; $display("FAIL rs_word0: got %h expected d0", mem_data); end
        tick();
        n_vec++; if (mem_data !== 16'hD1 || read_count !== 32'd7) begin n_err++; $display("FAIL rs_word1: got data=%h rc=%0d expected d1/7", mem_data, read_count); end
        bus.mem_addr = 23'h12; bus.mem_addr_valid = 1'b1;
        tick();
        bus.mem_addr_valid = 1'b0;
        n_vec++; if (bus.mem_wait !== 1'b1 || read_count !== 32'd7) begin n_err++; $display("FAIL rs_read_restart: got wait=%b rc=%0d expected 1/7", bus.mem_wait, read_count); end
        tick();
        n_vec++; if (mem_data !== 16'hA2) begin n_err++; $display("FAIL rs_read_word: got %h expected a2", mem_data); end
        end_burst();
    endtask

    task automatic test_wrap();
        write_burst(23'hFFF, 16'hB0, 2);
        start_read(23'hFFF);
        n_vec++; if (mem_data !== 16'hB0) begin n_err++; $display("FAIL wrap_top: got %h expected b0", mem_data); end
        tick();
        n_vec++; if (mem_data !== 16'hB1 || read_count !== 32'd8) begin n_err++; $display("FAIL wrap_zero: got data=%h rc=%0d expected b1/8", mem_data, read_count); end
        end_burst();
    endtask

    task automatic test_reset_mid_read();
        write_burst(23'h5, 16'h1234, 1);
        start_read(23'h5);
        n_vec++; if (mem_data !== 16'h1234) begin n_err++; $display("FAIL rmr_pre: got %h expected 1234", mem_data); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (dut.drive_en !== 1'b0 || burst_active !== 1'b0 || bus.mem_wait !== 1'b0) begin n_err++; $display("FAIL rmr_release: got drv=%b active=%b wait=%b expected 0/0/0", dut.drive_en, burst_active, bus.mem_wait); end
        n_vec++; if (write_count !== 32'd0 || read_count !== 32'd0) begin n_err++; $display("FAIL rmr_counts: got w=%0d r=%0d expected 0/0", write_count, read_count); end
        bus_idle();
        tick();
        reset = 1'b1;
        tick();
        start_read(23'h5);
        n_vec++; if (mem_data !== 16'h1234) begin n_err++; $display("FAIL rmr_retained: got %h expected 1234", mem_data); end
        tick();
        n_vec++; if (read_count !== 32'd1) begin n_err++; $display("FAIL rmr_rc: got %0d expected 1", read_count); end
        end_burst();
    endtask

    task automatic test_bounds();
`ifdef CELLRAM_RESPONDER_BOUNDS_EN
        n_vec++; if (addr_error !== 1'b0) begin n_err++; $display("FAIL bnd_clear: got %b expected 0", addr_error); end
        write_burst(23'h001000, 16'hEEEE, 1);
        n_vec++; if (addr_error !== 1'b1 || write_count !== 32'd0) begin n_err++; $display("FAIL bnd_write: got err=%b wc=%0d expected 1/0", addr_error, write_count); end
        start_read(23'h001000);
        n_vec++; if (mem_data !== 16'hDEAD) begin n_err++; $display("FAIL bnd_read: got %h expected dead", mem_data); end
        tick();
        n_vec++; if (read_count !== 32'd2 || addr_error !== 1'b1) begin n_err++; $display("FAIL bnd_rc: got rc=%0d err=%b expected 2/1", read_count, addr_error); end
        end_burst();
        tick();
        n_vec++; if (addr_error !== 1'b1) begin n_err++; $display("FAIL bnd_sticky: got %b expected 1", addr_error); end
        reset = 1'b0;
        #1;
        n_vec++; if (addr_error !== 1'b0) begin n_err++; $display("FAIL bnd_reset: got %b expected 0", addr_error); end
        reset = 1'b1;
        tick();
`else
        write_burst(23'h001000, 16'h5A5A, 1);
        n_vec++; if (addr_error !== 1'b0 || write_count !== 32'd1) begin n_err++; $display("FAIL alias_write: got err=%b wc=%0d expected 0/1", addr_error, write_count); end
        start_read(23'h000000);
        n_vec++; if (mem_data !== 16'h5A5A) begin n_err++; $display("FAIL alias_read: got %h expected 5a5a", mem_data); end
        end_burst();
        n_vec++; if (addr_error !== 1'b0) begin n_err++; $display("FAIL alias_err: got %b expected 0", addr_error); end
`endif
    endtask

    initial begin
        bus.mem_addr = '0;
        bus_idle();
        repeat (2) tick();
        test_reset();
        test_write_burst();
        test_read_burst();
        test_pause();
        test_contention();
        test_restart();
`ifndef CELLRAM_RESPONDER_BOUNDS_EN
        test_wrap();
`endif
        test_reset_mid_read();
        test_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
